// File: rtl/sdram_port_arbiter.sv
// Two-port round-robin arbiter onto one Avalon-MM SDRAM slave. Grants land on m_* one cycle after an idle request.
// Commands are held under m_waitrequest, and reads stall while the ID FIFO is full. Read data is steered with zero added latency.
module sdram_port_arbiter #(
    parameter int ADDR_W   = 24,
    parameter int DATA_W   = 16,
    parameter int MAX_PEND = 8
) (
    input  logic                clk_clk,
    input  logic                reset_reset,
    input  logic [ADDR_W-1:0]   r0_address,
    input  logic                r0_read,
    input  logic                r0_write,
    input  logic [DATA_W-1:0]   r0_writedata,
    input  logic [DATA_W/8-1:0] r0_byteenable,
    output logic                r0_waitrequest,
    output logic [DATA_W-1:0]   r0_readdata,
    output logic                r0_readdatavalid,
    input  logic [ADDR_W-1:0]   r1_address,
    input  logic                r1_read,
    input  logic                r1_write,
    input  logic [DATA_W-1:0]   r1_writedata,
    input  logic [DATA_W/8-1:0] r1_byteenable,
    output logic                r1_waitrequest,
    output logic [DATA_W-1:0]   r1_readdata,
    output logic                r1_readdatavalid,
    output logic [ADDR_W-1:0]   m_address,
    output logic                m_read,
    output logic                m_write,
    output logic [DATA_W-1:0]   m_writedata,
    output logic [DATA_W/8-1:0] m_byteenable,
    input  logic                m_waitrequest,
    input  logic [DATA_W-1:0]   m_readdata,
    input  logic                m_readdatavalid,
    output logic                orphan_err
);
    localparam int PW = $clog2(MAX_PEND);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t              state;
    logic                last_grant;
    logic [MAX_PEND-1:0] pend_id;
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [PW:0]         count;
    logic                fifo_full;
    logic                fifo_empty;
    logic                head_id;
    logic                req0;
    logic                req1;
    logic                own0;
    logic                own1;
    logic                accept;
    logic                push;
    logic                pop;

    assign req0       = r0_read | r0_write;
    assign req1       = r1_read | r1_write;
    assign own0       = (state == OWN0);
    assign own1       = (state == OWN1);
    // MAX_PEND is a power of two, so the counter MSB alone marks full.
    assign fifo_full  = count[PW];
    assign fifo_empty = (count == '0);
    assign head_id    = pend_id[rd_ptr];

    assign m_address    = own1 ? r1_address    : r0_address;
    assign m_writedata  = own1 ? r1_writedata  : r0_writedata;
    assign m_byteenable = own1 ? r1_byteenable : r0_byteenable;
    assign m_read       = ((own0 & r0_read) | (own1 & r1_read)) & ~fifo_full;
    assign m_write      = (own0 & r0_write) | (own1 & r1_write);

    assign accept = (m_read | m_write) & ~m_waitrequest;
    assign push   = accept & m_read;
    assign pop    = m_readdatavalid & ~fifo_empty;

    assign r0_waitrequest = ~own0 | m_waitrequest | (r0_read & fifo_full);
    assign r1_waitrequest = ~own1 | m_waitrequest | (r1_read & fifo_full);

    assign r0_readdata      = m_readdata;
    assign r1_readdata      = m_readdata;
    assign r0_readdatavalid = pop & ~head_id;
    assign r1_readdatavalid = pop & head_id;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 & req1)
                        state <= last_grant ? OWN0 : OWN1;
                    else if (req0)
                        state <= OWN0;
                    else if (req1)
                        state <= OWN1;
                end
                OWN0: begin
                    if (accept) begin
                        last_grant <= 1'b0;
                        if (req1)
                            state <= OWN1;
                        else if (!req0)
                            state <= IDLE;
                    end else if (!req0) begin
                        state <= IDLE;
                    end
                end
                OWN1: begin
                    if (accept) begin
                        last_grant <= 1'b1;
                        if (req0)
                            state <= OWN0;
                        else if (!req1)
                            state <= IDLE;
                    end else if (!req1) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ID storage needs no reset: entries are only read behind the counter.
    always_ff @(posedge clk_clk) begin
        if (push)
            pend_id[wr_ptr] <= own1;
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            orphan_err <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push & ~pop)
                count <= count + 1'b1;
            else if (pop & ~push)
                count <= count - 1'b1;
            if (m_readdatavalid & fifo_empty)
                orphan_err <= 1'b1;
        end
    end
endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Two-port round-robin arbiter sharing the single Avalon-MM slave of the SDRAM controller between two requesters, e.g. a camera frame writer and a display frame reader. It sits between the requesters and the SDRAM controller's slave port, in the same clock domain. It forwards one command per grant and tracks outstanding pipelined reads so returning read data is steered to the requester that issued the read.

## Interface
Parameters:
- ADDR_W, 24: word address width (13 row + 9 col + 2 bank).
- DATA_W, 16: data width; byteenable is DATA_W/8 bits.
- MAX_PEND, 8: maximum outstanding reads, a power of two ≥ 2.

Ports:
- clk_clk  in  1  system clock; all logic rises on this edge.
- reset_reset  in  1  synchronous, active-high reset.
- rN_address  in  ADDR_W  requester N address (N = 0, 1; same set per port).
- rN_read, rN_write  in  1  command strobes; never both high.
- rN_writedata  in  DATA_W  write data.
- rN_byteenable  in  DATA_W/8  byte lanes.
- rN_waitrequest  out  1  command not accepted this cycle.
- rN_readdata  out  DATA_W  read data.
- rN_readdatavalid  out  1  read data valid for requester N.
- m_address, m_read, m_write, m_writedata, m_byteenable  out  as above  to the SDRAM controller.
- m_waitrequest  in  1  controller stall.
- m_readdata  in  DATA_W  controller read data.
- m_readdatavalid  in  1  controller read data valid.
- orphan_err  out  1  sticky: readdatavalid arrived with no read pending.

## Operation
- States: IDLE, OWN0, OWN1. The state register holds the current owner; last_grant holds the most recent owner (reset value 1, so port 0 wins the first tie).
- IDLE: if exactly one requester asserts read or write, go to its OWN state. If both assert, grant the port ≠ last_grant. m_read and m_write are 0 in IDLE.
- OWN N: forward requester N's command fields to m_*. m_read is gated off while the pending FIFO is full.
- Acceptance: accept = (m_read | m_write) & !m_waitrequest. On accept:
  - set last_grant = N;
  - if the other port is requesting, go to OWN(other);
  - else if port N is still requesting, stay in OWN N;
  - else go to IDLE.
- While N holds the grant and is not accepted, the grant never changes. Avalon requires command hold, so no command is preempted.
- If the owner drops its request without acceptance (illegal per Avalon), return to IDLE next cycle.
- rN_waitrequest = !(state == OWN N) | m_waitrequest | (rN_read & fifo_full).
- Pending FIFO, MAX_PEND × 1 bit of requester ID:
  - push the owner ID on an accepted read;
  - pop on m_readdatavalid;
  - occupancy counter is log2(MAX_PEND)+1 bits wide.
  - Full blocks new reads even if a pop occurs in the same cycle.
  - Push and pop in the same cycle when not full leaves the count unchanged.
- Read return:
  - rN_readdata = m_readdata on both ports;
  - rN_readdatavalid = m_readdatavalid & !fifo_empty & (head ID == N).
- Writes never enter the FIFO. Reads and writes interleave freely; read-data order follows command order.
- m_readdatavalid with the FIFO empty: drop the beat and set orphan_err, which clears only on reset.

## Timing
- Reset values: state IDLE, last_grant 1, FIFO empty, orphan_err 0, all m_read/m_write 0, rN_waitrequest 1, rN_readdatavalid 0.
- Grant latency: a request in IDLE is registered and reaches m_* one cycle later. The requester sees waitrequest high for at least that first cycle.
- Back-to-back: consecutive accepts need no idle cycle. Alternating ports reach one command per cycle when m_waitrequest is low.
- Read data path is combinational: zero added latency from m_readdatavalid to rN_readdatavalid.
- Reset mid-operation clears the FIFO and state in the same cycle. Read beats arriving afterwards raise orphan_err; the controller is expected to reset on the same line.

## Test plan
- Single requester: after reset, r0 issues read at 0x000100; m_read is seen one cycle later. With a 3-cycle controller latency, r0_readdatavalid pulses with readdata 0xBEEF, and r1_readdatavalid stays 0.
- Contention: r0 and r1 both hold writes continuously with m_waitrequest=0. Grants go 0,1,0,1…; accepts are 1 per cycle after the first; last_grant toggles every cycle.
- Hold under stall: r1 is owner and m_waitrequest is held high 5 cycles while r0 also requests. m_address stays r1's address for all 5 cycles; r0 is granted on the cycle after r1 is accepted.
- FIFO full: MAX_PEND=8 with controller data withheld. The 9th read sees r0_waitrequest high. Releasing one readdatavalid frees the slot, and the 9th read is accepted on the next cycle.
- Routing: interleave reads r0, r1, r1, r0 with data 1, 2, 3, 4. Required: r0 gets 1 and 4, r1 gets 2 and 3, in order.
- Orphan/reset: readdatavalid with no pending read sets orphan_err=1, which stays set; reset_reset for 1 cycle clears it. Asserting reset mid-burst returns all outputs to reset values on the next edge.
